wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: DEPTH, 2, ALU-result buffer entries (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: alu_valid  input  1  ALU result offered.
REQ-005 SHALL have port: alu_ready  output  1  buffer can accept an ALU result.
REQ-006 SHALL have port: alu_rd  input  4  ALU destination register.
REQ-007 SHALL have port: alu_data  input  32  ALU result.
REQ-008 SHALL have port: ld_valid  input  1  load result present; never back-pressured.
REQ-009 SHALL have port: ld_rd  input  4  load destination register.
REQ-010 SHALL have port: ld_data  input  32  load result.
REQ-011 SHALL have port: rf_w_en  output  1  register-file write enable.
REQ-012 SHALL have port: rf_rd_addr  output  4  register-file write address.
REQ-013 SHALL have port: rf_rd_data  output  32  register-file write data.
REQ-014 SHALL have port: busy  output  1  at least one valid buffered ALU entry.

Function
REQ-015 SHALL accept an ALU result on any edge where alu_valid and alu_ready are both high.
REQ-016 SHALL store accepted ALU results in a DEPTH-entry in-order FIFO; each entry holds rd, data and a live bit.
REQ-017 SHALL drive alu_ready = (occupancy < DEPTH) from registered occupancy; a pop in the same cycle does not raise alu_ready.
REQ-018 SHALL select, each cycle, one write: load if ld_valid, else FIFO head if non-empty, else none.
REQ-019 SHALL pop the FIFO head only when it is selected; a head with live=0 is popped with no write.
REQ-020 SHALL register the selection into rf_w_en/rf_rd_addr/rf_rd_data one edge later: load at cycle N -> rf_w_en at N+1.
REQ-021 SHALL give ALU latency of 2 cycles with an empty FIFO and no load: accepted at N -> rf_w_en at N+2.
REQ-022 SHALL, when ld_valid, clear the live bit of every buffered entry whose rd equals ld_rd (younger load supersedes).
REQ-023 SHALL, when an ALU result is accepted in the same cycle as a load to the same rd, push it with live=0.
REQ-024 SHALL let consecutive loads starve the FIFO indefinitely; alu_ready falls when full.
REQ-025 SHALL hold rf_rd_addr/rf_rd_data at their last values while rf_w_en is low.
REQ-026 SHALL assert busy iff any FIFO entry has live=1, from registered state.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH with occupancy kept in log2(DEPTH)+1 bits.

Reset
REQ-028 SHALL, on rst_n low, immediately clear occupancy, pointers and live bits; force rf_w_en=0, rf_rd_addr=0, rf_rd_data=0, busy=0, alu_ready=0.
REQ-029 SHALL drive alu_ready=1 from the first edge after rst_n deasserts; reset mid-operation discards all buffered results with no write.

Configuration
REQ-030 SHALL, with macro WB_FWD_EN defined, add outputs fwd_valid(1), fwd_addr(4), fwd_data(32) = the combinational current-cycle selection of REQ-018, only for live writes.
REQ-031 SHALL, without WB_FWD_EN, omit those ports and all related logic; the other behaviour is identical.

Verification
REQ-032 SHALL cover: ALU rd=3 data=0x11 at cycle 0 with the bus otherwise idle -> rf_w_en=1, rf_rd_addr=3, rf_rd_data=0x11 at cycle 2.
REQ-033 SHALL cover: load rd=5 data=0xAA at cycle 0 -> write 5/0xAA at cycle 1; ALU rd=6 also sent at cycle 0 -> 6 written at cycle 2.
REQ-034 SHALL cover: ALU rd=7 data=0x1 buffered, then load rd=7 data=0x2 -> only 7/0x2 written; no later write to r7.
REQ-035 SHALL cover: DEPTH=2, ld_valid held high 5 cycles while ALU sends 3 results -> alu_ready=0 after 2 accepts; buffered values written in order after loads stop.
REQ-036 SHALL cover: rst_n pulsed low with 2 entries buffered -> busy=0 and rf_w_en=0 immediately; no write after release.
REQ-037 SHALL cover: with WB_FWD_EN, load rd=2 data=0x55 -> fwd_valid=1, fwd_addr=2, fwd_data=0x55 in the same cycle; rf write follows at the next edge.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: merges unbuffered load results and a small in-order
// ALU-result FIFO into one register-file write port; loads win.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   alu_valid/ready ALU result handshake
//   alu_rd/data     ALU destination register and result
//   ld_valid/rd/data load result, never back-pressured
//   rf_w_en/rd_addr/rd_data registered register-file write
//   busy            some buffered ALU entry is still live
//   fwd_valid/addr/data current-cycle live write (WB_FWD_EN only)
//
// Optional feature: define WB_FWD_EN to add the forwarding outputs.
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [3:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        rf_w_en,
  output logic [3:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data,
`ifdef WB_FWD_EN
  output logic        fwd_valid,
  output logic [3:0]  fwd_addr,
  output logic [31:0] fwd_data,
`endif
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        live;
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t          buf_q [DEPTH];
  ent_t          head;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic          rdy_q;

  logic          push;
  logic          pop;
  logic          sel_we;
  logic [3:0]    sel_rd;
  logic [31:0]   sel_data;

  assign head      = buf_q[rd_q];
  // rdy_q keeps ready low while in reset and for no longer
  assign alu_ready = rdy_q & (cnt_q < FULL);
  assign push      = alu_valid & alu_ready;

  // Load has priority; a dead head is still popped, just not written
  always_comb begin
    sel_we   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    pop      = 1'b0;
    if (ld_valid) begin
      sel_we   = 1'b1;
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end else if (cnt_q != '0) begin
      pop      = 1'b1;
      sel_we   = head.live;
      sel_rd   = head.rd;
      sel_data = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_q <= AW'(wr_q + 1'b1);
      if (pop)  rd_q <= AW'(rd_q + 1'b1);
    end
  end

  // Later assignments override: a fresh push beats the load kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_valid && buf_q[i].rd == ld_rd)
          buf_q[i].live <= 1'b0;
      end
      if (pop) buf_q[rd_q].live <= 1'b0;
      if (push) begin
        buf_q[wr_q].live <= ~(ld_valid && ld_rd == alu_rd);
        buf_q[wr_q].rd   <= alu_rd;
        buf_q[wr_q].data <= alu_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en    <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else begin
      rf_w_en <= sel_we;
      if (sel_we) begin
        rf_rd_addr <= sel_rd;
        rf_rd_data <= sel_data;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | buf_q[i].live;
  end

`ifdef WB_FWD_EN
  assign fwd_valid = sel_we;
  assign fwd_addr  = sel_rd;
  assign fwd_data  = sel_data;
`endif

endmodule
